// File: rtl/inst_fetch_unit.sv
// Instruction fetch for the RV32I core: owns the PC, keeps one request outstanding to
// instruction memory, and hands each fetched word to decode through a one-entry buffer.
module inst_fetch_unit #(
    parameter logic [31:0] ENTRY_ADDRESS   = 32'h8000_0000,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_jump_flag,
    input  logic [31:0] io_jump_address,
    output logic        io_imem_req_valid,
    input  logic        io_imem_req_ready,
    output logic [31:0] io_imem_addr,
    input  logic        io_imem_resp_valid,
    input  logic [31:0] io_imem_resp_data,
    output logic [31:0] io_instruction,
    output logic [31:0] io_instruction_address,
    output logic        io_instruction_valid,
    input  logic        io_instruction_ready
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] buf_inst;
    logic [31:0] buf_pc;
    logic        kill;

    logic [31:0] jump_target;
    logic        req_fire;
    logic        dec_fire;

    // Handshakes: a request transfers on a cycle where req_valid && req_ready; the
    // response is valid-only (one per accepted request); decode consumes the held
    // word on a cycle where instruction_valid && instruction_ready.
    assign jump_target = {io_jump_address[31:2], 2'b00};
    assign req_fire    = io_imem_req_valid && io_imem_req_ready;
    assign dec_fire    = io_instruction_valid && io_instruction_ready;

    assign io_imem_req_valid      = (state == ST_REQ) && reset;
    assign io_imem_addr           = pc;
    assign io_instruction_valid   = (state == ST_HOLD) && reset;
    assign io_instruction         = io_instruction_valid ? buf_inst : NOP_INSTRUCTION;
    assign io_instruction_address = buf_pc;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_REQ;
            pc       <= ENTRY_ADDRESS;
            kill     <= 1'b0;
            buf_inst <= NOP_INSTRUCTION;
            buf_pc   <= ENTRY_ADDRESS;
        end else begin
            case (state)
                ST_REQ: begin
                    if (req_fire) begin
                        state <= ST_WAIT;
                        // A jump on the accepting cycle makes the in-flight word stale.
                        kill  <= io_jump_flag;
                        if (io_jump_flag) pc <= jump_target;
                    end else if (io_jump_flag) begin
                        pc <= jump_target;
                    end
                end
                ST_WAIT: begin
                    if (io_imem_resp_valid) begin
                        if (!kill && !io_jump_flag) begin
                            buf_inst <= io_imem_resp_data;
                            buf_pc   <= pc;
                            state    <= ST_HOLD;
                        end else begin
                            kill  <= 1'b0;
                            state <= ST_REQ;
                            if (io_jump_flag) pc <= jump_target;
                        end
                    end else if (io_jump_flag) begin
                        kill <= 1'b1;
                        pc   <= jump_target;
                    end
                end
                ST_HOLD: begin
                    if (dec_fire) begin
                        state <= ST_REQ;
                        pc    <= io_jump_flag ? jump_target : pc + 32'd4;
                    end else if (io_jump_flag) begin
                        state <= ST_REQ;
                        pc    <= jump_target;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Cycle-by-cycle directed vectors for inst_fetch_unit: inputs driven on the falling
// edge, state-derived outputs compared 1 ns later against hand-computed values.
module tb_inst_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ENT  = 32'h8000_0000;
    localparam logic [31:0] I1   = 32'h0010_0093;
    localparam logic [31:0] I2   = 32'h0020_8113;
    localparam logic [31:0] I3   = 32'h0031_0193;
    localparam logic [31:0] I4   = 32'h0040_0213;
    localparam logic [31:0] I5   = 32'h0050_0293;
    localparam logic [31:0] I6   = 32'h0060_0313;
    localparam logic [31:0] BAD  = 32'hDEAD_BEEF;

    logic        clock;
    logic        reset;
    logic        io_jump_flag;
    logic [31:0] io_jump_address;
    logic        io_imem_req_valid;
    logic        io_imem_req_ready;
    logic [31:0] io_imem_addr;
    logic        io_imem_resp_valid;
    logic [31:0] io_imem_resp_data;
    logic [31:0] io_instruction;
    logic [31:0] io_instruction_address;
    logic        io_instruction_valid;
    logic        io_instruction_ready;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic        jf;
        logic [31:0] ja;
        logic        rqr;
        logic        rsv;
        logic [31:0] rsd;
        logic        ir;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_ia;
    } vec_t;

    vec_t tbl[$];

    inst_fetch_unit dut (
        .clock                  (clock),
        .reset                  (reset),
        .io_jump_flag           (io_jump_flag),
        .io_jump_address        (io_jump_address),
        .io_imem_req_valid      (io_imem_req_valid),
        .io_imem_req_ready      (io_imem_req_ready),
        .io_imem_addr           (io_imem_addr),
        .io_imem_resp_valid     (io_imem_resp_valid),
        .io_imem_resp_data      (io_imem_resp_data),
        .io_instruction         (io_instruction),
        .io_instruction_address (io_instruction_address),
        .io_instruction_valid   (io_instruction_valid),
        .io_instruction_ready   (io_instruction_ready)
    );

    // Clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic vec_t mk(input logic jf, input logic [31:0] ja, input logic rqr,
                                input logic rsv, input logic [31:0] rsd, input logic ir,
                                input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                                input logic [31:0] e_inst, input logic [31:0] e_ia);
        vec_t v;
        v.rst = 1'b1; v.jf = jf; v.ja = ja; v.rqr = rqr; v.rsv = rsv; v.rsd = rsd; v.ir = ir;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_ia = e_ia;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver: one vector per clock cycle
    task automatic apply(input vec_t v, input string tag);
        @(negedge clock);
        reset                = v.rst;
        io_jump_flag         = v.jf;
        io_jump_address      = v.ja;
        io_imem_req_ready    = v.rqr;
        io_imem_resp_valid   = v.rsv;
        io_imem_resp_data    = v.rsd;
        io_instruction_ready = v.ir;
        #1;
        check({tag, ".req_valid"}, {31'b0, io_imem_req_valid}, {31'b0, v.e_rv});
        check({tag, ".imem_addr"}, io_imem_addr, v.e_addr);
        check({tag, ".inst_valid"}, {31'b0, io_instruction_valid}, {31'b0, v.e_iv});
        check({tag, ".inst"}, io_instruction, v.e_inst);
        check({tag, ".inst_addr"}, io_instruction_address, v.e_ia);
        check({tag, ".inst_addr_align"}, {30'b0, io_instruction_address[1:0]}, 32'd0);
    endtask

    initial begin
        vec_t v;
        reset = 1'b0; io_jump_flag = 1'b0; io_jump_address = '0; io_imem_req_ready = 1'b0;
        io_imem_resp_valid = 1'b0; io_imem_resp_data = '0; io_instruction_ready = 1'b0;

        // Reset held low 3 cycles, memory ready throughout
        for (int i = 0; i < 3; i++) begin
            v = mk(0, 0, 1, 0, 0, 1, 0, ENT, 0, NOP, ENT);
            v.rst = 1'b0;
            tbl.push_back(v);
        end
        //       jf  ja            rqr rsv rsd  ir   rv addr          iv inst ia
        // Basic fetch: REQ, WAIT, HOLD
        tbl.push_back(mk(0, 0,            1, 0, 0,   1,   1, ENT,          0, NOP, ENT));
        tbl.push_back(mk(0, 0,            1, 1, I1,  1,   0, ENT,          0, NOP, ENT));
        tbl.push_back(mk(0, 0,            1, 0, 0,   1,   0, ENT,          1, I1,  ENT));
        // Decode stalls 5 cycles in HOLD; a stray response there is ignored
        tbl.push_back(mk(0, 0,            1, 0, 0,   1,   1, 32'h8000_0004, 0, NOP, ENT));
        tbl.push_back(mk(0, 0,            1, 1, I2,  0,   0, 32'h8000_0004, 0, NOP, ENT));
        tbl.push_back(mk(0, 0,            1, 0, 0,   0,   0, 32'h8000_0004, 1, I2,  32'h8000_0004));
        tbl.push_back(mk(0, 0,            1, 1, BAD, 0,   0, 32'h8000_0004, 1, I2,  32'h8000_0004));
        tbl.push_back(mk(0, 0,            1, 0, 0,   0,   0, 32'h8000_0004, 1, I2,  32'h8000_0004));
        tbl.push_back(mk(0, 0,            1, 0, 0,   0,   0, 32'h8000_0004, 1, I2,  32'h8000_0004));
        tbl.push_back(mk(0, 0,            1, 0, 0,   0,   0, 32'h8000_0004, 1, I2,  32'h8000_0004));
        tbl.push_back(mk(0, 0,            1, 0, 0,   1,   0, 32'h8000_0004, 1, I2,  32'h8000_0004));
        // Memory not ready for 4 cycles; a response in REQ is ignored
        tbl.push_back(mk(0, 0,            0, 0, 0,   1,   1, 32'h8000_0008, 0, NOP, 32'h8000_0004));
        tbl.push_back(mk(0, 0,            0, 1, BAD, 1,   1, 32'h8000_0008, 0, NOP, 32'h8000_0004));
        tbl.push_back(mk(0, 0,            0, 0, 0,   1,   1, 32'h8000_0008, 0, NOP, 32'h8000_0004));
        tbl.push_back(mk(0, 0,            0, 0, 0,   1,   1, 32'h8000_0008, 0, NOP, 32'h8000_0004));
        tbl.push_back(mk(0, 0,            1, 0, 0,   1,   1, 32'h8000_0008, 0, NOP, 32'h8000_0004));
        tbl.push_back(mk(0, 0,            1, 1, I3,  1,   0, 32'h8000_0008, 0, NOP, 32'h8000_0004));
        tbl.push_back(mk(0, 0,            1, 0, 0,   1,   0, 32'h8000_0008, 1, I3,  32'h8000_0008));
        // Jump in WAIT, stale response 2 cycles later is discarded
        tbl.push_back(mk(0, 0,            1, 0, 0,   1,   1, 32'h8000_000C, 0, NOP, 32'h8000_0008));
        tbl.push_back(mk(1, 32'h8000_0102, 1, 0, 0,  1,   0, 32'h8000_000C, 0, NOP, 32'h8000_0008));
        tbl.push_back(mk(0, 0,            1, 0, 0,   1,   0, 32'h8000_0100, 0, NOP, 32'h8000_0008));
        tbl.push_back(mk(0, 0,            1, 1, BAD, 1,   0, 32'h8000_0100, 0, NOP, 32'h8000_0008));
        tbl.push_back(mk(0, 0,            1, 0, 0,   1,   1, 32'h8000_0100, 0, NOP, 32'h8000_0008));
        tbl.push_back(mk(0, 0,            1, 1, I4,  1,   0, 32'h8000_0100, 0, NOP, 32'h8000_0008));
        // Jump coincident with decode fire wins over pc+4
        tbl.push_back(mk(1, 32'h8000_0040, 1, 0, 0,  1,   0, 32'h8000_0100, 1, I4,  32'h8000_0100));
        tbl.push_back(mk(0, 0,            1, 0, 0,   1,   1, 32'h8000_0040, 0, NOP, 32'h8000_0100));
        tbl.push_back(mk(0, 0,            1, 1, I5,  0,   0, 32'h8000_0040, 0, NOP, 32'h8000_0100));
        // Jump in HOLD without fire, jump in REQ without fire, jump on request fire
        tbl.push_back(mk(1, 32'h8000_0203, 1, 0, 0,  0,   0, 32'h8000_0040, 1, I5,  32'h8000_0040));
        tbl.push_back(mk(1, 32'h8000_0300, 0, 0, 0,  1,   1, 32'h8000_0200, 0, NOP, 32'h8000_0040));
        tbl.push_back(mk(1, 32'h8000_0400, 1, 0, 0,  1,   1, 32'h8000_0300, 0, NOP, 32'h8000_0040));
        tbl.push_back(mk(0, 0,            1, 1, BAD, 1,   0, 32'h8000_0400, 0, NOP, 32'h8000_0040));
        tbl.push_back(mk(0, 0,            1, 0, 0,   1,   1, 32'h8000_0400, 0, NOP, 32'h8000_0040));
        // Jump coincident with a response drops the response
        tbl.push_back(mk(1, 32'h8000_0500, 1, 1, BAD, 1,  0, 32'h8000_0400, 0, NOP, 32'h8000_0040));
        tbl.push_back(mk(0, 0,            1, 0, 0,   1,   1, 32'h8000_0500, 0, NOP, 32'h8000_0040));
        tbl.push_back(mk(0, 0,            1, 1, I6,  1,   0, 32'h8000_0500, 0, NOP, 32'h8000_0040));
        tbl.push_back(mk(0, 0,            0, 0, 0,   1,   0, 32'h8000_0500, 1, I6,  32'h8000_0500));
        // Two jumps in WAIT: the last one wins
        tbl.push_back(mk(0, 0,            1, 0, 0,   1,   1, 32'h8000_0504, 0, NOP, 32'h8000_0500));
        tbl.push_back(mk(1, 32'h8000_0600, 1, 0, 0,  1,   0, 32'h8000_0504, 0, NOP, 32'h8000_0500));
        tbl.push_back(mk(1, 32'h8000_0700, 1, 0, 0,  1,   0, 32'h8000_0600, 0, NOP, 32'h8000_0500));
        tbl.push_back(mk(0, 0,            1, 1, BAD, 1,   0, 32'h8000_0700, 0, NOP, 32'h8000_0500));
        tbl.push_back(mk(0, 0,            0, 0, 0,   1,   1, 32'h8000_0700, 0, NOP, 32'h8000_0500));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Hand sequence: PC wraps from 0xFFFF_FFFC to 0 (jump target low bits masked)
        apply(mk(1, 32'hFFFF_FFFF, 0, 0, 0,  1,  1, 32'h8000_0700, 0, NOP, 32'h8000_0500), "wrap0");
        apply(mk(0, 0,             1, 0, 0,  1,  1, 32'hFFFF_FFFC, 0, NOP, 32'h8000_0500), "wrap1");
        apply(mk(0, 0,             1, 1, I1, 1,  0, 32'hFFFF_FFFC, 0, NOP, 32'h8000_0500), "wrap2");
        apply(mk(0, 0,             1, 0, 0,  1,  0, 32'hFFFF_FFFC, 1, I1,  32'hFFFF_FFFC), "wrap3");
        apply(mk(0, 0,             1, 0, 0,  1,  1, 32'h0000_0000, 0, NOP, 32'hFFFF_FFFC), "wrap4");

        // Hand sequence: reset during WAIT, the late response is ignored
        v = mk(0, 0, 0, 0, 0, 1, 0, 32'h0000_0000, 0, NOP, 32'hFFFF_FFFC);
        v.rst = 1'b0;
        apply(v, "rstwait0");
        apply(mk(0, 0,             0, 1, BAD, 1, 1, ENT, 0, NOP, ENT), "rstwait1");
        apply(mk(0, 0,             1, 0, 0,   1, 1, ENT, 0, NOP, ENT), "rstwait2");
        apply(mk(0, 0,             1, 1, I2,  1, 0, ENT, 0, NOP, ENT), "rstwait3");
        apply(mk(0, 0,             1, 0, 0,   1, 0, ENT, 1, I2,  ENT), "rstwait4");
        apply(mk(0, 0,             0, 0, 0,   1, 1, 32'h8000_0004, 0, NOP, ENT), "rstwait5");

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
